// File: rtl/ec_core_zout.sv
// Result read-out unit: reduces (zp - zn) mod P with word-serial subtract/correct passes,
// holds the canonical result and streams it LSW-first over a 32-bit valid/ready port.
module ec_core_zout #(
  parameter logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         z_start,
  input  logic         z_clr,
  input  logic [255:0] ma_zp,
  input  logic [255:0] ma_zn,
  output logic         z_busy,
  output logic         z_done,
  output logic [255:0] z_out,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic         rd_last,
  input  logic         rd_ready
);

  typedef enum logic [1:0] {IDLE, SUB, ADD, OUT} state_t;

  state_t        state_q, state_d;
  logic [255:0]  acc_q, acc_d;
  logic [255:0]  zn_q, zn_d;
  logic [255:0]  z_out_q, z_out_d;
  logic [3:0]    w_q, w_d;
  logic          cy_q, cy_d;
  logic          z_done_q, z_done_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [2:0]    wi;
  logic [2:0]    wn;
  logic [7:0]    bit_base;
  logic [32:0]   diff;
  logic [32:0]   sum;

  // w counts 0..7 over the words; the extra value 8 is the settle cycle before entering OUT,
  // so z_out is loaded only after the last word has been written back into acc.
  always_comb begin
    wi       = w_q[2:0];
    wn       = wi + 3'd1;
    bit_base = {wi, 5'd0};
    diff     = {1'b0, acc_q[bit_base +: 32]} - {1'b0, zn_q[bit_base +: 32]} - {32'd0, cy_q};
    sum      = {1'b0, acc_q[bit_base +: 32]} + {1'b0, P[bit_base +: 32]} + {32'd0, cy_q};

    state_d    = state_q;
    acc_d      = acc_q;
    zn_d       = zn_q;
    z_out_d    = z_out_q;
    w_d        = w_q;
    cy_d       = cy_q;
    z_done_d   = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;

    if (z_clr) begin
      state_d    = IDLE;
      acc_d      = '0;
      zn_d       = '0;
      z_out_d    = '0;
      w_d        = '0;
      cy_d       = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (z_start) begin
            acc_d   = ma_zp;
            zn_d    = ma_zn;
            w_d     = '0;
            cy_d    = 1'b0;
            state_d = SUB;
          end
        end
        SUB, ADD: begin
          if (w_q[3]) begin
            state_d    = OUT;
            z_out_d    = acc_q;
            z_done_d   = 1'b1;
            rd_valid_d = 1'b1;
            rd_data_d  = acc_q[31:0];
            rd_last_d  = 1'b0;
            w_d        = '0;
          end else if (state_q == SUB) begin
            acc_d[bit_base +: 32] = diff[31:0];
            if (wi == 3'd7 && diff[32]) begin
              state_d = ADD;
              w_d     = '0;
              cy_d    = 1'b0;
            end else begin
              cy_d = diff[32];
              w_d  = w_q + 4'd1;
            end
          end else begin
            acc_d[bit_base +: 32] = sum[31:0];
            cy_d = sum[32];
            w_d  = w_q + 4'd1;
          end
        end
        OUT: begin
          if (rd_valid_q && rd_ready) begin
            if (wi == 3'd7) begin
              state_d    = IDLE;
              rd_valid_d = 1'b0;
              rd_last_d  = 1'b0;
              rd_data_d  = '0;
              w_d        = '0;
            end else begin
              w_d       = {1'b0, wn};
              rd_data_d = acc_q[{wn, 5'd0} +: 32];
              rd_last_d = (wn == 3'd7);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      zn_q       <= '0;
      z_out_q    <= '0;
      w_q        <= '0;
      cy_q       <= 1'b0;
      z_done_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      zn_q       <= zn_d;
      z_out_q    <= z_out_d;
      w_q        <= w_d;
      cy_q       <= cy_d;
      z_done_q   <= z_done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign z_busy   = (state_q != IDLE);
  assign z_done   = z_done_q;
  assign z_out    = z_out_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_ec_core_zout.sv
// Randomized self-checking bench for ec_core_zout against a modular-arithmetic reference model.
module tb_ec_core_zout;

  localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         z_start = 1'b0;
  logic         z_clr = 1'b0;
  logic [255:0] ma_zp = '0;
  logic [255:0] ma_zn = '0;
  logic         z_busy;
  logic         z_done;
  logic [255:0] z_out;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         rd_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;
  logic [255:0] lastZ = '0;

  ec_core_zout dut (
    .clk(clk), .rst_n(rst_n), .z_start(z_start), .z_clr(z_clr),
    .ma_zp(ma_zp), .ma_zn(ma_zn), .z_busy(z_busy), .z_done(z_done),
    .z_out(z_out), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Reference: z = (zp - zn) mod P for operands already below P
  function automatic logic [255:0] refZ(input logic [255:0] zp, input logic [255:0] zn);
    logic [256:0] t;
    if (zp >= zn) t = {1'b0, zp} - {1'b0, zn};
    else          t = {1'b0, zp} + {1'b0, P} - {1'b0, zn};
    return t[255:0];
  endfunction

  function automatic logic [255:0] randOperand();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    if (r >= P) r = r - P;
    return r;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, z_busy, 0);
    checkOutput({tag, "_done"}, z_done, 0);
    checkOutput({tag, "_zout"}, z_out, 0);
    checkOutput({tag, "_valid"}, rd_valid, 0);
    checkOutput({tag, "_data"}, rd_data, 0);
    checkOutput({tag, "_last"}, rd_last, 0);
  endtask

  // One full operation: start, wait for z_done, then drain the stream under the chosen ready pattern
  task automatic applyStimulus(input logic [255:0] zp, input logic [255:0] zn,
                               input int readyMode, input bit spurious);
    logic [255:0] expZ;
    int expLat, cycles, idx, guard;
    bit prevStall;
    logic [31:0] prevData;
    logic prevLast;
    expZ = refZ(zp, zn);
    expLat = (zp >= zn) ? 9 : 17;
    rd_ready = 1'b1;
    z_start = 1'b1;
    ma_zp = zp;
    ma_zn = zn;
    @(posedge clk); #1;
    z_start = 1'b0;
    checkOutput("busy_rise", z_busy, 1);
    cycles = 0;
    while (!z_done && cycles < 40) begin
      if (spurious && cycles == 3) begin
        z_start = 1'b1;
        ma_zp = randOperand();
        ma_zn = randOperand();
      end
      @(posedge clk); #1;
      z_start = 1'b0;
      cycles++;
      if (cycles == 2) checkOutput("zout_hold", z_out, lastZ);
    end
    checkOutput("latency", cycles, expLat);
    checkOutput("zout", z_out, expZ);
    lastZ = expZ;

    idx = 0;
    guard = 0;
    prevStall = 1'b0;
    prevData = '0;
    prevLast = 1'b0;
    while (idx < 8 && guard < 100) begin
      case (readyMode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (guard % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (prevStall) begin
        checkOutput("hold_data", rd_data, prevData);
        checkOutput("hold_last", rd_last, prevLast);
      end
      checkOutput("rd_valid", rd_valid, 1);
      checkOutput("busy_stream", z_busy, 1);
      if (rd_ready) begin
        checkOutput($sformatf("word%0d", idx), rd_data, expZ[idx*32 +: 32]);
        checkOutput($sformatf("last%0d", idx), rd_last, (idx == 7));
        idx++;
        prevStall = 1'b0;
      end else begin
        prevStall = 1'b1;
        prevData = rd_data;
        prevLast = rd_last;
      end
      @(posedge clk); #1;
      guard++;
      if (guard == 1) checkOutput("done_pulse", z_done, 0);
    end
    checkOutput("words", idx, 8);
    checkOutput("busy_fall", z_busy, 0);
    checkOutput("valid_fall", rd_valid, 0);
    rd_ready = 1'b1;
  endtask

  initial begin
    int doneSeen;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(256'd5, 256'd3, 0, 0);
    checkOutput("vec_5_3", z_out, 256'd2);
    applyStimulus(256'd3, 256'd5, 0, 0);
    checkOutput("vec_p_minus_2", z_out,
                256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFD);
    applyStimulus(P - 256'd1, P - 256'd1, 0, 0);
    checkOutput("vec_equal", z_out, 256'd0);
    applyStimulus(P - 256'd1, 256'd0, 0, 0);
    checkOutput("vec_p_minus_1", z_out, P - 256'd1);
    applyStimulus(256'd0, P - 256'd1, 1, 0);
    checkOutput("vec_one", z_out, 256'd1);
    applyStimulus(randOperand(), randOperand(), 1, 1);

    $display("[TB] clear during SUB");
    z_start = 1'b1;
    ma_zp = randOperand();
    ma_zn = randOperand();
    @(posedge clk); #1;
    z_start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    z_clr = 1'b1;
    @(posedge clk); #1;
    z_clr = 1'b0;
    checkAllZero("clr");
    lastZ = '0;
    doneSeen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (z_done || rd_valid) doneSeen++;
    end
    checkOutput("clr_no_done", doneSeen, 0);

    $display("[TB] reset during ADD");
    z_start = 1'b1;
    ma_zp = 256'd3;
    ma_zn = 256'd5;
    @(posedge clk); #1;
    z_start = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_busy", z_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    lastZ = '0;
    @(posedge clk); #1;
    applyStimulus(256'd7, 256'd2, 0, 0);
    checkOutput("vec_7_2", z_out, 256'd5);

    $display("[TB] randomized operations");
    for (int n = 0; n < 12; n++) begin
      logic [255:0] a, b;
      a = randOperand();
      b = randOperand();
      applyStimulus(a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
